// File: rtl/led_pattern_if.sv
// Bundles the pattern-select controls and LED outputs of the LED pattern generator.
// The master side drives mode/pause/step_req. The slave side returns led/tick/dir.
interface led_pattern_if #(
   parameter int WIDTH = 8
);
   logic [1:0]       mode;
   logic             pause;
   logic             step_req;
   logic [WIDTH-1:0] led;
   logic             tick;
   logic             dir;

   modport master (
      output mode, pause, step_req,
      input  led, tick, dir
   );

   modport slave (
      input  mode, pause, step_req,
      output led, tick, dir
   );
endinterface

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left, rotate-right, bounce or binary count.
// Steps come from a free-running prescaler, or from manual requests while paused.
module led_pattern_gen #(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 5000000,
   parameter int CNT_W    = 32
) (
   input  logic         clk,
   input  logic         rst,
   led_pattern_if.slave bus
);
   typedef enum logic [1:0] {
      MODE_ROL    = 2'b00,
      MODE_ROR    = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_COUNT  = 2'b11
   } mode_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] LED_LSB  = WIDTH'(1);
   localparam logic [WIDTH-1:0] LED_MSB  = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0] led_q, led_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             tick_q, tick_d;
   logic [1:0]       mode_q;

   logic             mode_change;
   logic             auto_step;
   logic             step;
   logic [WIDTH-1:0] bounce_led;

   always_comb begin
      mode_change = (bus.mode != mode_q);
      auto_step   = !bus.pause && (cnt_q == CNT_LAST);
      step        = auto_step || (bus.pause && bus.step_req);
      bounce_led  = dir_q ? (led_q << 1) : (led_q >> 1);

      led_d  = led_q;
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      tick_d = 1'b0;

      // A mode change restarts the pattern and overrides any step in the same cycle.
      if (mode_change) begin
         led_d = LED_LSB;
         cnt_d = '0;
         dir_d = 1'b1;
      end else begin
         if (!bus.pause) begin
            cnt_d = auto_step ? '0 : cnt_q + CNT_W'(1);
         end
         if (step) begin
            tick_d = 1'b1;
            case (bus.mode)
               MODE_ROL: led_d = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
               MODE_ROR: led_d = {led_q[0], led_q[WIDTH-1:1]};
               MODE_BOUNCE: begin
                  led_d = bounce_led;
                  if (bounce_led == LED_MSB) begin
                     dir_d = 1'b0;
                  end else if (bounce_led == LED_LSB) begin
                     dir_d = 1'b1;
                  end
               end
               default: led_d = led_q + WIDTH'(1);
            endcase
         end
      end
   end

   // mode_q tracks mode even in reset so releasing reset never looks like a mode change.
   always_ff @(posedge clk) begin
      mode_q <= bus.mode;
      if (rst) begin
         led_q  <= LED_LSB;
         cnt_q  <= '0;
         dir_q  <= 1'b1;
         tick_q <= 1'b0;
      end else begin
         led_q  <= led_d;
         cnt_q  <= cnt_d;
         dir_q  <= dir_d;
         tick_q <= tick_d;
      end
   end

   assign bus.led  = led_q;
   assign bus.tick = tick_q;
   assign bus.dir  = dir_q;
endmodule
